ls194_seq_arb: RTL and testbench

- Two-requester command sequencer for a 4-bit 74LS194-style universal shift register.
- Arbitrates round-robin between two command ports and accepts one command at a time over a valid/ready handshake.
- Drives the register's mode pins (M1, M0), serial inputs (DSR, DSL) and parallel data (D) for the required number of cycles, then pulses done.
- Sits between command sources and the shift register; owns no register state of its own.

---
 rtl/ls194_seq_arb.sv | 149 ++++++++++++++
 tb/tb_ls194_seq_arb.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ls194_seq_arb.sv
// ls194_seq_arb
// Two-port round-robin command sequencer for a 4-bit 74LS194-style universal
// shift register. One command at a time is accepted over a valid/ready
// handshake. The mode pins, serial inputs and parallel data are then driven
// for the command's cycle count, and done pulses when the command finishes.
//
// Ports
//   CLK, CLR          clock (rising edge), asynchronous active-low reset
//   reqN_valid/ready  command handshake for port N (N = 0, 1)
//   reqN_op           00 NOP, 01 SHR, 10 SHL, 11 LOAD
//   reqN_cnt          shift/hold cycles minus 1 (ignored for LOAD)
//   reqN_data         parallel load value
//   reqN_sin          serial bit fed during shifts
//   M1, M0            register mode: 00 hold, 01 right, 10 left, 11 load
//   DSR, DSL          serial inputs to the register
//   D                 parallel data to the register
//   busy              a command is executing
//   grant_id          port of the last accepted command
//   done              one-cycle pulse after the last mode cycle
//
// state | meaning
// IDLE  | no command running; arbiter may grant a port
// RUN   | driving captured mode/data until remaining reaches 0

module ls194_seq_arb #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [CNT_W-1:0] req0_cnt,
    input  logic [WIDTH-1:0] req0_data,
    input  logic             req0_sin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [CNT_W-1:0] req1_cnt,
    input  logic [WIDTH-1:0] req1_data,
    input  logic             req1_sin,
    output logic             M1,
    output logic             M0,
    output logic             DSR,
    output logic             DSL,
    output logic [WIDTH-1:0] D,
    output logic             busy,
    output logic             grant_id,
    output logic             done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [1:0] OP_LOAD = 2'b11;

    state_t             state, state_nxt;
    logic [1:0]         op_q;
    logic               sin_q;
    logic [CNT_W-1:0]   remaining;
    logic               last_grant;

    logic               sel_valid;
    logic               sel_port;
    logic               hs;
    logic [1:0]         sel_op;
    logic [CNT_W-1:0]   sel_cnt;
    logic [WIDTH-1:0]   sel_data;
    logic               sel_sin;
    logic               last_cycle;

    // Arbiter: a lone valid port wins; on contention the port that did not
    // win last time goes first.
    always_comb begin
        sel_valid = req0_valid | req1_valid;
        if (req0_valid && req1_valid)
            sel_port = ~last_grant;
        else
            sel_port = req1_valid;

        sel_op   = sel_port ? req1_op   : req0_op;
        sel_cnt  = sel_port ? req1_cnt  : req0_cnt;
        sel_data = sel_port ? req1_data : req0_data;
        sel_sin  = sel_port ? req1_sin  : req0_sin;
    end

    // The state already reads IDLE while CLR is low; gating with CLR keeps
    // both readies low for the whole reset window.
    assign req0_ready = CLR && (state == IDLE) && sel_valid && !sel_port;
    assign req1_ready = CLR && (state == IDLE) && sel_valid &&  sel_port;

    assign hs         = (state == IDLE) && sel_valid;
    assign last_cycle = (state == RUN) && (remaining == '0);

    always_comb begin
        state_nxt = state;
        M1        = 1'b0;
        M0        = 1'b0;
        DSR       = 1'b0;
        DSL       = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (hs)
                    state_nxt = RUN;
            end
            RUN: begin
                {M1, M0} = op_q;
                DSR      = sin_q;
                DSL      = sin_q;
                busy     = 1'b1;
                if (remaining == '0)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state      <= IDLE;
            op_q       <= 2'b00;
            sin_q      <= 1'b0;
            remaining  <= '0;
            D          <= '0;
            last_grant <= 1'b1;
            grant_id   <= 1'b0;
            done       <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= last_cycle;
            if (hs) begin
                op_q       <= sel_op;
                sin_q      <= sel_sin;
                D          <= sel_data;
                last_grant <= sel_port;
                grant_id   <= sel_port;
                // LOAD is a single-cycle command whatever cnt says.
                remaining  <= (sel_op == OP_LOAD) ? '0 : sel_cnt;
            end else if (state == RUN && remaining != '0) begin
                remaining <= remaining - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ls194_seq_arb.sv
module tb_ls194_seq_arb;

    logic       CLK = 1'b0;
    logic       CLR;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    logic [1:0] req0_op, req1_op;
    logic [2:0] req0_cnt, req1_cnt;
    logic [3:0] req0_data, req1_data;
    logic       req0_sin, req1_sin;
    logic       M1, M0, DSR, DSL;
    logic [3:0] D;
    logic       busy, grant_id, done;

    ls194_seq_arb #(.WIDTH(4), .CNT_W(3)) dut (
        .CLK(CLK), .CLR(CLR),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_cnt(req0_cnt), .req0_data(req0_data), .req0_sin(req0_sin),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_cnt(req1_cnt), .req1_data(req1_data), .req1_sin(req1_sin),
        .M1(M1), .M0(M0), .DSR(DSR), .DSL(DSL), .D(D),
        .busy(busy), .grant_id(grant_id), .done(done)
    );

    always #5 CLK = ~CLK;

    // Attached 74LS194 register, driven by the DUT outputs.
    logic       clr194 = 1'b0;
    logic [3:0] q194 = 4'b0000;
    always @(posedge CLK) begin
        if (clr194)
            q194 <= 4'b0000;
        else case ({M1, M0})
            2'b01:   q194 <= {DSR, q194[3:1]};
            2'b10:   q194 <= {q194[2:0], DSL};
            2'b11:   q194 <= D;
            default: q194 <= q194;
        endcase
    end

    // Command-level reference: each accepted command expands into a list of
    // cycles it must drive; the cycle after the list empties carries done.
    typedef struct {
        logic [1:0] op;
        logic       sin;
    } rec_t;
    rec_t       q_exp[$];
    logic       lg_m, gid_m, done_m;
    logic [3:0] data_m;
    int         hs_port;
    int         compared = 0;
    int         mism     = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mism++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int winner();
        if (req0_valid && req1_valid) return lg_m ? 0 : 1;
        if (req1_valid) return 1;
        return 0;
    endfunction

    task automatic model_reset();
        q_exp.delete();
        lg_m   = 1'b1;
        gid_m  = 1'b0;
        done_m = 1'b0;
        data_m = 4'b0000;
    endtask

    task automatic check_outputs();
        bit   idle = (q_exp.size() == 0);
        bit   any  = req0_valid || req1_valid;
        logic [1:0] m_e   = idle ? 2'b00 : q_exp[0].op;
        logic       sin_e = idle ? 1'b0  : q_exp[0].sin;
        chk("ready0", req0_ready, CLR && idle && any && winner() == 0);
        chk("ready1", req1_ready, CLR && idle && any && winner() == 1);
        chk("mode",   {M1, M0}, m_e);
        chk("dsr",    DSR, sin_e);
        chk("dsl",    DSL, sin_e);
        chk("d",      D, data_m);
        chk("busy",   busy, !idle);
        chk("grant",  grant_id, gid_m);
        chk("done",   done, done_m);
    endtask

    task automatic cyc();
        bit idle, dn;
        int w, n;
        @(negedge CLK);
        check_outputs();
        hs_port = -1;
        @(posedge CLK);
        if (CLR) begin
            idle = (q_exp.size() == 0);
            dn   = 1'b0;
            if (!idle) begin
                void'(q_exp.pop_front());
                dn = (q_exp.size() == 0);
            end
            if (idle && (req0_valid || req1_valid)) begin
                rec_t r;
                w = winner();
                r.op  = w ? req1_op  : req0_op;
                r.sin = w ? req1_sin : req0_sin;
                n = (r.op == 2'b11) ? 1 : int'(w ? req1_cnt : req0_cnt) + 1;
                for (int i = 0; i < n; i++) q_exp.push_back(r);
                data_m  = w ? req1_data : req0_data;
                lg_m    = w[0];
                gid_m   = w[0];
                hs_port = w;
            end
            done_m = dn;
        end
        #1;
    endtask

    task automatic issue(input int p, input logic [1:0] op, input logic [2:0] cnt,
                         input logic [3:0] data, input logic sin);
        int k;
        if (p == 0) begin
            req0_op = op; req0_cnt = cnt; req0_data = data; req0_sin = sin; req0_valid = 1'b1;
        end else begin
            req1_op = op; req1_cnt = cnt; req1_data = data; req1_sin = sin; req1_valid = 1'b1;
        end
        for (k = 0; k < 30; k++) begin
            cyc();
            if (hs_port == p) break;
        end
        chk("issue_timeout", k < 30, 1'b1);
        if (p == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    endtask

    task automatic run_idle();
        int k;
        for (k = 0; k < 40 && (q_exp.size() > 0 || done_m); k++) cyc();
        chk("idle_timeout", k < 40, 1'b1);
    endtask

    initial begin
        int seq[$];
        CLR = 1'b0;
        req0_valid = 0; req0_op = 0; req0_cnt = 0; req0_data = 0; req0_sin = 0;
        req1_valid = 0; req1_op = 0; req1_cnt = 0; req1_data = 0; req1_sin = 0;
        model_reset();

        // Reset state, including readies held low with a valid pending.
        req0_valid = 1'b1;
        cyc();
        cyc();
        req0_valid = 1'b0;
        CLR = 1'b1;

        // 1: LOAD 1010 on port 0.
        issue(0, 2'b11, 3'd5, 4'b1010, 1'b0);
        run_idle();
        chk("load_q194", q194, 4'b1010);

        // 2: SHR x3 with sin=1 on port 1 from an empty register.
        clr194 = 1'b1;
        cyc();
        clr194 = 1'b0;
        issue(1, 2'b01, 3'd2, 4'b0011, 1'b1);
        run_idle();
        chk("shr_q194", q194, 4'b1110);

        // 3: both ports contending with single-cycle SHL: grants alternate.
        req0_op = 2'b10; req0_cnt = 0; req0_sin = 1'b1; req0_data = 4'h5;
        req1_op = 2'b10; req1_cnt = 0; req1_sin = 1'b0; req1_data = 4'hA;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            cyc();
            if (hs_port >= 0) seq.push_back(hs_port);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        run_idle();
        chk("alt_count", seq.size(), 5);
        chk("alt_first", seq[0], 0);
        for (int i = 1; i < seq.size(); i++)
            chk("alt_order", seq[i], 1 - seq[i-1]);

        // 4: long SHL on port 0; port 1 arrives mid-command.
        issue(0, 2'b10, 3'd7, 4'b0110, 1'b0);
        for (int i = 0; i < 3; i++) cyc();
        req1_op = 2'b00; req1_cnt = 0; req1_valid = 1'b1;
        begin
            int k;
            for (k = 0; k < 20 && hs_port != 1; k++) cyc();
            chk("late_grant", k < 20, 1'b1);
        end
        req1_valid = 1'b0;
        run_idle();

        // 6: NOP leaves the register untouched.
        issue(0, 2'b11, 3'd0, 4'b0110, 1'b0);
        run_idle();
        issue(1, 2'b00, 3'd3, 4'b1111, 1'b1);
        run_idle();
        chk("nop_q194", q194, 4'b0110);

        // 5: reset during the second cycle of a SHR cnt=5 from port 0.
        issue(0, 2'b01, 3'd5, 4'b1001, 1'b1);
        cyc();
        CLR = 1'b0;
        #1;
        model_reset();
        check_outputs();
        cyc();
        cyc();
        CLR = 1'b1;
        req0_op = 2'b11; req0_data = 4'h3; req1_op = 2'b11; req1_data = 4'hC;
        req0_valid = 1'b1; req1_valid = 1'b1;
        cyc();
        chk("post_reset_grant", hs_port, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        run_idle();

        // Randomised traffic, including field changes while busy and
        // valids dropped without a handshake.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                req0_valid = 1'($urandom_range(0, 1));
                req0_op    = 2'($urandom_range(0, 3));
                req0_cnt   = 3'($urandom_range(0, 7));
                req0_data  = 4'($urandom_range(0, 15));
                req0_sin   = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 3) == 0) begin
                req1_valid = 1'($urandom_range(0, 1));
                req1_op    = 2'($urandom_range(0, 3));
                req1_cnt   = 3'($urandom_range(0, 7));
                req1_data  = 4'($urandom_range(0, 15));
                req1_sin   = 1'($urandom_range(0, 1));
            end
            cyc();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        run_idle();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end

endmodule
